// File: rtl/resp_pkg.sv
// Shared types for the QSPI programmer response path.
// A frame is one completed command: {seq, tag, err, data}, 81 bits.
// It goes to the host as three 32-bit words: header, data[63:32], data[31:0].
package resp_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_WORDS   = 3;

  // Header word field positions
  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_SEQ_LSB  = 16;
  localparam int HDR_ERR_BIT  = 8;
  localparam int HDR_TAG_LSB  = 0;

  typedef struct packed {
    logic [7:0]  seq;
    logic [7:0]  tag;
    logic        err;
    logic [63:0] data;
  } frame_t;

  typedef enum logic [1:0] {
    W_HDR = 2'd0,
    W_HI  = 2'd1,
    W_LO  = 2'd2
  } word_e;

  // Select one of the FRAME_WORDS output words of a frame
  function automatic logic [31:0] frame_word(input frame_t f, input word_e w,
                                             input logic [7:0] sync);
    logic [31:0] hdr;
    hdr                        = '0;
    hdr[HDR_SYNC_LSB +: 8]     = sync;
    hdr[HDR_SEQ_LSB +: 8]      = f.seq;
    hdr[HDR_ERR_BIT]           = f.err;
    hdr[HDR_TAG_LSB +: 8]      = f.tag;
    case (w)
      W_HDR:   return hdr;
      W_HI:    return f.data[63:32];
      default: return f.data[31:0];
    endcase
  endfunction

endpackage

// File: rtl/dword_response_if.sv
// Host-link word stream of the response path.
//   data_to_PC : current response word
//   valid      : data_to_PC holds a word
//   rd         : host consumes the word when valid && rd
// master = response block, slave = host link.
interface dword_response_if;
  logic [31:0] data_to_PC;
  logic        valid;
  logic        rd;

  modport master (output data_to_PC, output valid, input rd);
  modport slave  (input data_to_PC, input valid, output rd);
endinterface

// File: rtl/resp_fifo.sv
// Single-clock frame FIFO.
//   push/wdata : write request; push_ok says whether it was taken
//   pop/rdata  : rdata is the head frame; pop removes it
//   full/empty/count : occupancy
// A push while full is still accepted when the same cycle pops, because the
// slot being freed is reused.
module resp_fifo
  import resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       push,
  input  frame_t                     wdata,
  input  logic                       pop,
  output frame_t                     rdata,
  output logic                       full,
  output logic                       empty,
  output logic                       push_ok,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  frame_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop_ok;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dword_response.sv
// Response path to the PC for the QSPI programmer.
// Detects the falling edge of the controller busy flag, and for each armed
// command queues a frame {seq, tag, error, readout}. Each frame is streamed
// to the host as three words over the valid/rd handshake.
//   clk_in, reset        : clock, synchronous active-high reset
//   cmd_issued, cmd_tag  : command handed to the controller (arms capture)
//   mc_busy              : controller busy, asynchronous to clk_in
//   readout, error       : controller result, stable while it is idle
//   host                 : data_to_PC / valid / rd word stream
//   pending              : frames queued
//   overflow, ovf_clr    : sticky drop flag and its clear
module dword_response
  import resp_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       cmd_issued,
  input  logic [7:0]                 cmd_tag,
  input  logic                       mc_busy,
  input  logic [63:0]                readout,
  input  logic                       error,
  dword_response_if.master           host,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  // busy_sync_q[0]=s1, [1]=s2 (synchronised), [2]=s3 (history)
  logic [2:0] busy_sync_q, busy_sync_d;
  logic       armed_q, armed_d;
  logic [7:0] tag_q, tag_d;
  logic [7:0] seq_q, seq_d;
  logic       push_q, push_d;
  frame_t     frame_q, frame_d;
  word_e      idx_q, idx_d;
  logic       overflow_q, overflow_d;

  logic       completion;
  logic       accept;
  logic       pop;
  frame_t     head;
  logic       fifo_full, fifo_empty, push_ok;

  resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .reset   (reset),
    .push    (push_q),
    .wdata   (frame_q),
    .pop     (pop),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (push_ok),
    .count   (pending)
  );

  always_comb begin
    busy_sync_d = {busy_sync_q[1:0], mc_busy};
    completion  = !busy_sync_q[1] && busy_sync_q[2];

    armed_d    = armed_q;
    tag_d      = tag_q;
    seq_d      = seq_q;
    push_d     = 1'b0;
    frame_d    = frame_q;

    // Completions while unarmed come from the controller's own power-up busy
    // period and carry no command, so they are ignored.
    if (completion && armed_q) begin
      push_d  = 1'b1;
      frame_d = '{seq: seq_q, tag: tag_q, err: error, data: readout};
      // seq advances even if the frame is dropped later, so the host sees a gap
      seq_d   = seq_q + 8'd1;
      armed_d = 1'b0;
    end
    // A new command re-arms; a second one before completion replaces the tag
    if (cmd_issued) begin
      armed_d = 1'b1;
      tag_d   = cmd_tag;
    end

    accept = !fifo_empty && host.rd;
    pop    = accept && (idx_q == W_LO);
    idx_d  = idx_q;
    if (accept) begin
      case (idx_q)
        W_HDR:   idx_d = W_HI;
        W_HI:    idx_d = W_LO;
        default: idx_d = W_HDR;
      endcase
    end

    // Drop wins over a clear in the same cycle
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (push_q && !push_ok) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      busy_sync_q <= 3'b111;
      armed_q     <= 1'b0;
      tag_q       <= '0;
      seq_q       <= '0;
      push_q      <= 1'b0;
      frame_q     <= '0;
      idx_q       <= W_HDR;
      overflow_q  <= 1'b0;
    end else begin
      busy_sync_q <= busy_sync_d;
      armed_q     <= armed_d;
      tag_q       <= tag_d;
      seq_q       <= seq_d;
      push_q      <= push_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      overflow_q  <= overflow_d;
    end
  end

  assign host.valid      = !fifo_empty;
  assign host.data_to_PC = fifo_empty ? 32'd0 : frame_word(head, idx_q, SYNC_BYTE);
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_dword_response.sv
module tb_dword_response;
  logic        clk_in = 1'b0;
  logic        reset;
  logic        cmd_issued;
  logic [7:0]  cmd_tag;
  logic        mc_busy;
  logic [63:0] readout;
  logic        error;
  logic [2:0]  pending;
  logic        overflow;
  logic        ovf_clr;

  dword_response_if host_if();

  dword_response #(.DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .cmd_issued (cmd_issued),
    .cmd_tag    (cmd_tag),
    .mc_busy    (mc_busy),
    .readout    (readout),
    .error      (error),
    .host       (host_if),
    .pending    (pending),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #8 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; cmd_issued = 1'b0; cmd_tag = '0; mc_busy = 1'b1;
    readout = '0; error = 1'b0; ovf_clr = 1'b0; host_if.rd = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  // Issue a command, then drop mc_busy. Returns just after the FIFO write edge
  // (mc_busy sampled low at edge N, write at N+3). v_before is valid sampled
  // after N+2; rd/ovf_clr can be asserted for the write-edge cycle only.
  task automatic complete(input logic [7:0] tag, input logic [63:0] data,
                          input logic err, input bit rd_at_push,
                          input bit clr_at_push, output logic v_before);
    mc_busy = 1'b1; cmd_issued = 1'b1; cmd_tag = tag; readout = data; error = err;
    tick;
    cmd_issued = 1'b0;
    tick; tick; tick;
    mc_busy = 1'b0;
    tick;            // N
    tick;            // N+1
    tick;            // N+2
    v_before = host_if.valid;
    if (rd_at_push)  host_if.rd = 1'b1;
    if (clr_at_push) ovf_clr = 1'b1;
    tick;            // N+3
    if (rd_at_push)  host_if.rd = 1'b0;
    if (clr_at_push) ovf_clr = 1'b0;
  endtask

  task automatic test_reset_and_unarmed;
    do_reset;
    checks++; if (host_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", host_if.valid); end
    checks++; if (host_if.data_to_PC !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", host_if.data_to_PC); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    mc_busy = 1'b0;
    repeat (6) tick;
    checks++; if (host_if.valid !== 1'b0) begin errors++; $display("FAIL unarmed_valid got=%b exp=0", host_if.valid); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL unarmed_pending got=%0d exp=0", pending); end
  endtask

  // Runs without a reset after the unarmed completion: header seq must be 0
  task automatic test_single_frame;
    logic vb;
    complete(8'h0B, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0, vb);
    checks++; if (vb !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", vb); end
    checks++; if (host_if.valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", host_if.valid); end
    checks++; if (pending !== 3'd1) begin errors++; $display("FAIL single_pending got=%0d exp=1", pending); end
    checks++; if (host_if.data_to_PC !== 32'hA500_000B) begin errors++; $display("FAIL single_w0 got=%h exp=A500000B", host_if.data_to_PC); end
    host_if.rd = 1'b1;
    tick;
    checks++; if (host_if.valid !== 1'b1 || host_if.data_to_PC !== 32'h0123_4567) begin errors++; $display("FAIL single_w1 got=%b/%h exp=1/01234567", host_if.valid, host_if.data_to_PC); end
    tick;
    checks++; if (host_if.valid !== 1'b1 || host_if.data_to_PC !== 32'h89AB_CDEF) begin errors++; $display("FAIL single_w2 got=%b/%h exp=1/89ABCDEF", host_if.valid, host_if.data_to_PC); end
    tick;
    checks++; if (host_if.valid !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL single_drained got=%b/%0d exp=0/0", host_if.valid, pending); end
    host_if.rd = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic vb;
    logic [31:0] exp_w [6];
    exp_w = '{32'hA500_0003, 32'h1111_2222, 32'h3333_4444,
              32'hA501_0105, 32'h5555_6666, 32'h7777_8888};
    do_reset;
    complete(8'h03, 64'h1111_2222_3333_4444, 1'b0, 0, 0, vb);
    complete(8'h05, 64'h5555_6666_7777_8888, 1'b1, 0, 0, vb);
    checks++; if (pending !== 3'd2) begin errors++; $display("FAIL b2b_pending got=%0d exp=2", pending); end
    host_if.rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (host_if.valid !== 1'b1 || host_if.data_to_PC !== exp_w[i]) begin
        errors++; $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", i, host_if.valid, host_if.data_to_PC, exp_w[i]);
      end
      tick;
    end
    checks++; if (host_if.valid !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL b2b_drained got=%b/%0d exp=0/0", host_if.valid, pending); end
    host_if.rd = 1'b0;
  endtask

  task automatic test_overflow;
    logic vb;
    logic [31:0] exp_h;
    do_reset;
    for (int i = 0; i < 5; i++)
      complete(8'h10 + 8'(i), {32'(i), 32'hC0DE_0000 | 32'(i)}, 1'b0, 0, 0, vb);
    checks++; if (pending !== 3'd4) begin errors++; $display("FAIL ovf_pending got=%0d exp=4", pending); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    ovf_clr = 1'b1; tick; ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    host_if.rd = 1'b1;
    for (int f = 0; f < 4; f++) begin
      exp_h = {8'hA5, 8'(f), 8'h00, 8'h10 + 8'(f)};
      checks++;
      if (host_if.data_to_PC !== exp_h) begin errors++; $display("FAIL ovf_hdr%0d got=%h exp=%h", f, host_if.data_to_PC, exp_h); end
      tick; tick; tick;
    end
    host_if.rd = 1'b0;
    checks++; if (host_if.valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", host_if.valid); end
    complete(8'h20, 64'hDEAD_BEEF_0000_0001, 1'b0, 0, 0, vb);
    checks++; if (host_if.data_to_PC !== 32'hA505_0020) begin errors++; $display("FAIL ovf_gap_seq got=%h exp=A5050020", host_if.data_to_PC); end
  endtask

  task automatic test_full_push_with_pop;
    logic vb;
    logic [31:0] exp_h;
    do_reset;
    for (int i = 0; i < 4; i++)
      complete(8'h30 + 8'(i), {32'hAAAA_0000 | 32'(i), 32'hBBBB_0000 | 32'(i)}, 1'b0, 0, 0, vb);
    checks++; if (pending !== 3'd4) begin errors++; $display("FAIL fullpop_fill got=%0d exp=4", pending); end
    host_if.rd = 1'b1; tick; tick; host_if.rd = 1'b0;
    checks++; if (host_if.data_to_PC !== 32'hBBBB_0000) begin errors++; $display("FAIL fullpop_at_w2 got=%h exp=BBBB0000", host_if.data_to_PC); end
    complete(8'h40, 64'h4444_0000_4444_0001, 1'b0, 1, 0, vb);
    checks++; if (pending !== 3'd4) begin errors++; $display("FAIL fullpop_pending got=%0d exp=4", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got=%b exp=0", overflow); end
    host_if.rd = 1'b1;
    for (int f = 1; f < 5; f++) begin
      exp_h = (f == 4) ? 32'hA504_0040 : {8'hA5, 8'(f), 8'h00, 8'h30 + 8'(f)};
      checks++;
      if (host_if.data_to_PC !== exp_h) begin errors++; $display("FAIL fullpop_hdr%0d got=%h exp=%h", f, host_if.data_to_PC, exp_h); end
      tick; tick; tick;
    end
    host_if.rd = 1'b0;
  endtask

  task automatic test_ovf_set_wins;
    logic vb;
    do_reset;
    for (int i = 0; i < 4; i++)
      complete(8'h50 + 8'(i), 64'(i), 1'b0, 0, 0, vb);
    complete(8'h58, 64'h0, 1'b0, 0, 1, vb);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL setwins_overflow got=%b exp=1", overflow); end
    checks++; if (pending !== 3'd4) begin errors++; $display("FAIL setwins_pending got=%0d exp=4", pending); end
  endtask

  task automatic test_reset_mid_frame;
    logic vb;
    do_reset;
    complete(8'h60, 64'h6060_6060_0000_0060, 1'b0, 0, 0, vb);
    complete(8'h61, 64'h6161_6161_0000_0061, 1'b0, 0, 0, vb);
    host_if.rd = 1'b1; tick; tick; host_if.rd = 1'b0;
    checks++; if (host_if.data_to_PC !== 32'h0000_0060) begin errors++; $display("FAIL midrst_w2 got=%h exp=00000060", host_if.data_to_PC); end
    reset = 1'b1; tick; reset = 1'b0;
    checks++; if (host_if.valid !== 1'b0 || pending !== 3'd0 || host_if.data_to_PC !== 32'd0) begin
      errors++; $display("FAIL midrst_state got=%b/%0d/%h exp=0/0/0", host_if.valid, pending, host_if.data_to_PC);
    end
    complete(8'h62, 64'h6262_6262_0000_0062, 1'b1, 0, 0, vb);
    checks++; if (host_if.data_to_PC !== 32'hA500_0162) begin errors++; $display("FAIL midrst_seq got=%h exp=A5000162", host_if.data_to_PC); end
    checks++; if (pending !== 3'd1) begin errors++; $display("FAIL midrst_pending got=%0d exp=1", pending); end
  endtask

  initial begin
    test_reset_and_unarmed;
    test_single_frame;
    test_back_to_back;
    test_overflow;
    test_full_push_with_pop;
    test_ovf_set_wins;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
